// File: rtl/evg_seq_pkg.sv
// Shared types and width helpers for the multi-table event sequencer.
package evg_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME0 = 2'd1,
        ST_PRIME1 = 2'd2,
        ST_RUN    = 2'd3
    } seqState_t;

    localparam logic [7:0] DEFAULT_EOT_CODE = 8'h7F;

    function automatic int selWidth(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    function automatic int addrWidth(input int capacity);
        return (capacity > 1) ? $clog2(capacity) : 1;
    endfunction

endpackage

// File: rtl/evg_seq_ram.sv
// Table storage: one write port, one read port with a registered output.
// Contents are deliberately left unreset.
module evg_seq_ram #(
    parameter int DATA_W = 36,
    parameter int ADDR_W = 13
) (
    input  logic              evgTxClk,
    input  logic              wrEnable,
    input  logic [ADDR_W-1:0] wrAddress,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddress,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge evgTxClk) begin
        if (wrEnable) begin
            mem[wrAddress] <= wrData;
        end
        rdData <= mem[rdAddress];
    end

endmodule

// File: rtl/evg_multi_sequencer.sv
// Plays one armed event table (of SEQUENCE_COUNT) per start, once, N times or forever.
// Optional statistics counters are built only when EVG_SEQ_STATS_EN is defined.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | waiting for a start while a table is armed
//   ST_PRIME0 | RAM read of entry 0 of the active table in flight
//   ST_PRIME1 | entry 0 loaded as pending event, entry 1 prefetched
//   ST_RUN    | gap countdown, then emit pending event or end the pass
module evg_multi_sequencer
    import evg_seq_pkg::*;
#(
    parameter int SEQUENCE_COUNT        = 4,
    parameter int SEQUENCE_RAM_CAPACITY = 2048,
    parameter int EVENTCODE_WIDTH       = 8,
    parameter int SEQUENCE_GAP_WIDTH    = 28,
    parameter logic [EVENTCODE_WIDTH-1:0] END_OF_TABLE_EVENT_CODE = EVENTCODE_WIDTH'(DEFAULT_EOT_CODE),
    localparam int SEL_W  = selWidth(SEQUENCE_COUNT),
    localparam int ADDR_W = addrWidth(SEQUENCE_RAM_CAPACITY)
) (
    input  logic                          evgTxClk,
    input  logic                          evgTxReset,
    input  logic                          wrEnable,
    input  logic [SEL_W+ADDR_W-1:0]       wrAddress,
    input  logic [SEQUENCE_GAP_WIDTH-1:0] wrGap,
    input  logic [EVENTCODE_WIDTH-1:0]    wrEvent,
    input  logic                          armStrobe,
    input  logic [SEL_W-1:0]              armSelect,
    input  logic [15:0]                   armRepeat,
    input  logic                          disarmStrobe,
    input  logic                          abortStrobe,
    input  logic [EVENTCODE_WIDTH-1:0]    precompletionEvent,
    input  logic                          evgSequenceStart,
    output logic [EVENTCODE_WIDTH-1:0]    evgSequenceEventTDATA,
    output logic                          evgSequenceEventTVALID,
    input  logic                          evgSequenceEventTREADY,
    output logic                          seqArmed,
    output logic                          seqActive,
    output logic                          seqBusy,
    output logic [SEL_W-1:0]              seqActiveSelect,
    output logic [15:0]                   seqPassesRemaining,
    output logic [7:0]                    startRequestsAccepted,
    output logic [7:0]                    startRequestsIgnored,
    output logic [15:0]                   stallCycles
);

    localparam int DATA_W = SEQUENCE_GAP_WIDTH + EVENTCODE_WIDTH;
    localparam int IDX_W  = ADDR_W + 1;
    localparam logic [IDX_W-1:0] CAP_IDX = IDX_W'(SEQUENCE_RAM_CAPACITY);

    seqState_t state, stateNext;

    logic [SEL_W-1:0]              armSel;
    logic [15:0]                   armRep;
    logic                          continuous;
    logic [SEQUENCE_GAP_WIDTH-1:0] gapCnt;
    logic [EVENTCODE_WIDTH-1:0]    pendingEvent;
    logic                          pendingOvf;
    logic [IDX_W-1:0]              nextIdx;
    logic [ADDR_W-1:0]             rdEntry;
    logic [DATA_W-1:0]             ramData;
    logic [SEQUENCE_GAP_WIDTH-1:0] ramGap;
    logic [EVENTCODE_WIDTH-1:0]    ramEvent;

    logic runZero, eventValid, passEnd, accept, finalPass, startAccept;

    evg_seq_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (SEL_W + ADDR_W)
    ) u_ram (
        .evgTxClk  (evgTxClk),
        .wrEnable  (wrEnable),
        .wrAddress (wrAddress),
        .wrData    ({wrGap, wrEvent}),
        .rdAddress ({seqActiveSelect, rdEntry}),
        .rdData    (ramData)
    );

    assign ramGap   = ramData[DATA_W-1:EVENTCODE_WIDTH];
    assign ramEvent = ramData[EVENTCODE_WIDTH-1:0];

    assign runZero     = (state == ST_RUN) && (gapCnt == '0);
    assign eventValid  = runZero && !pendingOvf && (pendingEvent != END_OF_TABLE_EVENT_CODE);
    assign passEnd     = runZero && (pendingOvf || (pendingEvent == END_OF_TABLE_EVENT_CODE));
    assign accept      = eventValid && evgSequenceEventTREADY;
    assign finalPass   = !continuous && (seqPassesRemaining <= 16'd1);
    assign startAccept = (state == ST_IDLE) && evgSequenceStart && seqArmed && !abortStrobe;

    assign evgSequenceEventTVALID = eventValid;
    assign evgSequenceEventTDATA  = eventValid ? pendingEvent : '0;

    always_ff @(posedge evgTxClk or posedge evgTxReset) begin
        if (evgTxReset) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // The read address always targets the entry that must sit on the RAM
    // output next cycle, so the prefetched entry is ready at each accept.
    always_comb begin
        stateNext = state;
        rdEntry   = nextIdx[ADDR_W-1:0];
        case (state)
            ST_IDLE: begin
                if (startAccept) stateNext = ST_PRIME0;
            end
            ST_PRIME0: begin
                stateNext = ST_PRIME1;
                rdEntry   = '0;
            end
            ST_PRIME1: begin
                stateNext = ST_RUN;
                rdEntry   = ADDR_W'(1);
            end
            ST_RUN: begin
                if (accept) rdEntry = nextIdx[ADDR_W-1:0] + ADDR_W'(1);
                if (passEnd) stateNext = finalPass ? ST_IDLE : ST_PRIME0;
            end
            default: stateNext = ST_IDLE;
        endcase
        if (abortStrobe) stateNext = ST_IDLE;
    end

    always_ff @(posedge evgTxClk or posedge evgTxReset) begin
        if (evgTxReset) begin
            seqArmed           <= 1'b0;
            armSel             <= '0;
            armRep             <= '0;
            seqActive          <= 1'b0;
            seqBusy            <= 1'b0;
            seqActiveSelect    <= '0;
            seqPassesRemaining <= '0;
            continuous         <= 1'b0;
            gapCnt             <= '0;
            pendingEvent       <= '0;
            pendingOvf         <= 1'b0;
            nextIdx            <= '0;
        end else begin
            // A strobe landing with an accepted start re-arms for the next start.
            if (disarmStrobe || abortStrobe) begin
                seqArmed <= 1'b0;
            end else if (armStrobe) begin
                seqArmed <= 1'b1;
                armSel   <= armSelect;
                armRep   <= armRepeat;
            end else if (startAccept) begin
                seqArmed <= 1'b0;
            end

            if (abortStrobe) begin
                seqActive <= 1'b0;
                seqBusy   <= 1'b0;
            end else begin
                if (startAccept) begin
                    seqActiveSelect    <= armSel;
                    seqPassesRemaining <= armRep;
                    continuous         <= (armRep == 16'd0);
                    seqActive          <= 1'b1;
                    seqBusy            <= 1'b1;
                end

                if (state == ST_PRIME1) begin
                    pendingEvent <= ramEvent;
                    gapCnt       <= ramGap;
                    pendingOvf   <= 1'b0;
                    nextIdx      <= IDX_W'(1);
                end else if (accept) begin
                    pendingEvent <= ramEvent;
                    pendingOvf   <= (nextIdx == CAP_IDX);
                    gapCnt       <= (nextIdx == CAP_IDX) ? '0 : ramGap;
                    nextIdx      <= nextIdx + IDX_W'(1);
                    if (finalPass && (pendingEvent == precompletionEvent)) seqBusy <= 1'b0;
                end else if ((state == ST_RUN) && (gapCnt != '0)) begin
                    gapCnt <= gapCnt - SEQUENCE_GAP_WIDTH'(1);
                end

                if (passEnd) begin
                    if (finalPass) begin
                        seqActive <= 1'b0;
                        seqBusy   <= 1'b0;
                    end else if (!continuous) begin
                        seqPassesRemaining <= seqPassesRemaining - 16'd1;
                    end
                end
            end
        end
    end

`ifdef EVG_SEQ_STATS_EN
    logic startIgnore, stall;

    assign startIgnore = (state != ST_IDLE) && evgSequenceStart && !abortStrobe;
    assign stall       = eventValid && !evgSequenceEventTREADY;

    always_ff @(posedge evgTxClk or posedge evgTxReset) begin
        if (evgTxReset) begin
            startRequestsAccepted <= '0;
            startRequestsIgnored  <= '0;
            stallCycles           <= '0;
        end else begin
            if (startAccept) startRequestsAccepted <= startRequestsAccepted + 8'd1;
            if (startIgnore) startRequestsIgnored  <= startRequestsIgnored + 8'd1;
            if (stall && (stallCycles != 16'hFFFF)) stallCycles <= stallCycles + 16'd1;
        end
    end
`else
    assign startRequestsAccepted = '0;
    assign startRequestsIgnored  = '0;
    assign stallCycles           = '0;
`endif

endmodule

// File: tb/tb_evg_multi_sequencer.sv
// Directed bench for evg_multi_sequencer: timing, repeats, stalls, aborts, reset.
module tb_evg_multi_sequencer;

    logic        evgTxClk = 1'b0;
    logic        evgTxReset;
    logic        wrEnable;
    logic [12:0] wrAddress;
    logic [27:0] wrGap;
    logic [7:0]  wrEvent;
    logic        armStrobe;
    logic [1:0]  armSelect;
    logic [15:0] armRepeat;
    logic        disarmStrobe;
    logic        abortStrobe;
    logic [7:0]  precompletionEvent;
    logic        evgSequenceStart;
    logic [7:0]  evgSequenceEventTDATA;
    logic        evgSequenceEventTVALID;
    logic        evgSequenceEventTREADY;
    logic        seqArmed, seqActive, seqBusy;
    logic [1:0]  seqActiveSelect;
    logic [15:0] seqPassesRemaining;
    logic [7:0]  startRequestsAccepted, startRequestsIgnored;
    logic [15:0] stallCycles;

    int nCompared   = 0;
    int nMismatched = 0;

`ifdef EVG_SEQ_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    evg_multi_sequencer dut (
        .evgTxClk               (evgTxClk),
        .evgTxReset             (evgTxReset),
        .wrEnable               (wrEnable),
        .wrAddress              (wrAddress),
        .wrGap                  (wrGap),
        .wrEvent                (wrEvent),
        .armStrobe              (armStrobe),
        .armSelect              (armSelect),
        .armRepeat              (armRepeat),
        .disarmStrobe           (disarmStrobe),
        .abortStrobe            (abortStrobe),
        .precompletionEvent     (precompletionEvent),
        .evgSequenceStart       (evgSequenceStart),
        .evgSequenceEventTDATA  (evgSequenceEventTDATA),
        .evgSequenceEventTVALID (evgSequenceEventTVALID),
        .evgSequenceEventTREADY (evgSequenceEventTREADY),
        .seqArmed               (seqArmed),
        .seqActive              (seqActive),
        .seqBusy                (seqBusy),
        .seqActiveSelect        (seqActiveSelect),
        .seqPassesRemaining     (seqPassesRemaining),
        .startRequestsAccepted  (startRequestsAccepted),
        .startRequestsIgnored   (startRequestsIgnored),
        .stallCycles            (stallCycles)
    );

    always #5 evgTxClk = ~evgTxClk;

    function automatic logic [31:0] statExp(input int n);
        return STATS_ON ? 32'(n) : 32'd0;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge evgTxClk);
        #1;
    endtask

    task automatic writeEntry(input logic [1:0] sel, input logic [10:0] idx,
                              input logic [27:0] gap, input logic [7:0] ev);
        wrAddress = {sel, idx};
        wrGap     = gap;
        wrEvent   = ev;
        wrEnable  = 1'b1;
        tick();
        wrEnable  = 1'b0;
    endtask

    task automatic armTable(input logic [1:0] sel, input logic [15:0] rep);
        armSelect = sel;
        armRepeat = rep;
        armStrobe = 1'b1;
        tick();
        armStrobe = 1'b0;
    endtask

    task automatic pulseStart();
        evgSequenceStart = 1'b1;
        tick();
        evgSequenceStart = 1'b0;
    endtask

    task automatic waitValid(input int startCnt, output int cnt);
        cnt = startCnt;
        while (!evgSequenceEventTVALID && cnt < 60) begin
            tick();
            cnt++;
        end
    endtask

    // Reference cycle is the start cycle (startCnt=1 after pulseStart) or the EOT cycle.
    task automatic expectPass(input string tag, input int startCnt, input int expDelay,
                              input int expRem, input logic expBusyAfter);
        int cnt;
        waitValid(startCnt, cnt);
        checkValue({tag, "-delay"}, cnt, expDelay);
        checkValue({tag, "-ev0"}, evgSequenceEventTDATA, 8'h10);
        checkValue({tag, "-rem"}, seqPassesRemaining, expRem);
        checkValue({tag, "-busy0"}, seqBusy, 1);
        tick();
        checkValue({tag, "-valid1"}, evgSequenceEventTVALID, 1);
        checkValue({tag, "-ev1"}, evgSequenceEventTDATA, 8'h11);
        checkValue({tag, "-busy1"}, seqBusy, expBusyAfter);
        tick();
        checkValue({tag, "-eotNoValid"}, evgSequenceEventTVALID, 0);
    endtask

    task automatic expectIdle(input string tag);
        checkValue({tag, "-active"}, seqActive, 0);
        checkValue({tag, "-busy"}, seqBusy, 0);
        checkValue({tag, "-valid"}, evgSequenceEventTVALID, 0);
    endtask

    initial begin
        int cnt;
        evgTxReset = 1'b1;
        wrEnable = 1'b0; wrAddress = '0; wrGap = '0; wrEvent = '0;
        armStrobe = 1'b0; armSelect = '0; armRepeat = '0;
        disarmStrobe = 1'b0; abortStrobe = 1'b0;
        precompletionEvent = 8'h55;
        evgSequenceStart = 1'b0;
        evgSequenceEventTREADY = 1'b1;
        tick();
        tick();
        evgTxReset = 1'b0;
        tick();

        checkValue("rst-valid", evgSequenceEventTVALID, 0);
        checkValue("rst-data", evgSequenceEventTDATA, 0);
        checkValue("rst-armed", seqArmed, 0);
        checkValue("rst-active", seqActive, 0);
        checkValue("rst-busy", seqBusy, 0);
        checkValue("rst-sel", seqActiveSelect, 0);
        checkValue("rst-rem", seqPassesRemaining, 0);
        checkValue("rst-acc", startRequestsAccepted, 0);
        checkValue("rst-ign", startRequestsIgnored, 0);
        checkValue("rst-stall", stallCycles, 0);

        writeEntry(2'd1, 11'd0, 28'd5, 8'h10);
        writeEntry(2'd1, 11'd1, 28'd0, 8'h11);
        writeEntry(2'd1, 11'd2, 28'd0, 8'h7F);
        writeEntry(2'd0, 11'd0, 28'd1, 8'h20);
        writeEntry(2'd0, 11'd1, 28'd0, 8'h7F);
        writeEntry(2'd2, 11'd0, 28'd0, 8'h7F);

        // Start without arming does nothing.
        pulseStart();
        checkValue("noArm-active", seqActive, 0);

        // Single pass of table 1.
        armTable(2'd1, 16'd1);
        checkValue("t1-armed", seqArmed, 1);
        pulseStart();
        checkValue("t1-active", seqActive, 1);
        checkValue("t1-busy", seqBusy, 1);
        checkValue("t1-armedCleared", seqArmed, 0);
        checkValue("t1-sel", seqActiveSelect, 1);
        checkValue("t1-acc", startRequestsAccepted, statExp(1));
        expectPass("t1", 1, 8, 1, 1'b1);
        checkValue("t1-eotActive", seqActive, 1);
        tick();
        expectIdle("t1-end");

        // Three passes.
        armTable(2'd1, 16'd3);
        pulseStart();
        expectPass("t2p1", 1, 8, 3, 1'b1);
        expectPass("t2p2", 0, 8, 2, 1'b1);
        expectPass("t2p3", 0, 8, 1, 1'b1);
        tick();
        expectIdle("t2-end");

        // Back-pressure for 7 cycles on the first event.
        armTable(2'd1, 16'd1);
        pulseStart();
        waitValid(1, cnt);
        checkValue("t3-delay", cnt, 8);
        evgSequenceEventTREADY = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checkValue("t3-holdValid", evgSequenceEventTVALID, 1);
            checkValue("t3-holdData", evgSequenceEventTDATA, 8'h10);
            tick();
        end
        evgSequenceEventTREADY = 1'b1;
        checkValue("t3-stillValid", evgSequenceEventTVALID, 1);
        tick();
        checkValue("t3-ev1", evgSequenceEventTDATA, 8'h11);
        checkValue("t3-ev1Valid", evgSequenceEventTVALID, 1);
        checkValue("t3-stall", stallCycles, statExp(7));
        tick();
        tick();
        expectIdle("t3-end");

        // Starts during playback are counted as ignored.
        armTable(2'd1, 16'd1);
        pulseStart();
        tick();
        tick();
        evgSequenceStart = 1'b1;
        tick();
        evgSequenceStart = 1'b0;
        tick();
        evgSequenceStart = 1'b1;
        tick();
        evgSequenceStart = 1'b0;
        expectPass("t4", 6, 8, 1, 1'b1);
        tick();
        expectIdle("t4-end");
        checkValue("t4-acc", startRequestsAccepted, statExp(4));
        checkValue("t4-ign", startRequestsIgnored, statExp(2));

        // Precompletion only acts on the final pass.
        precompletionEvent = 8'h10;
        armTable(2'd1, 16'd2);
        pulseStart();
        expectPass("t5p1", 1, 8, 2, 1'b1);
        checkValue("t5-busyBetween", seqBusy, 1);
        expectPass("t5p2", 0, 8, 1, 1'b0);
        checkValue("t5-activeAfterPre", seqActive, 1);
        tick();
        expectIdle("t5-end");
        precompletionEvent = 8'h55;

        // Table whose first entry is EOT: no event, back to idle.
        armTable(2'd2, 16'd1);
        pulseStart();
        checkValue("t6-sel", seqActiveSelect, 2);
        tick();
        checkValue("t6-noValidP1", evgSequenceEventTVALID, 0);
        tick();
        checkValue("t6-noValidRun", evgSequenceEventTVALID, 0);
        checkValue("t6-activeRun", seqActive, 1);
        tick();
        expectIdle("t6-end");

        // Disarm wins over a simultaneous arm; disarmed start does nothing.
        armSelect = 2'd1; armRepeat = 16'd1;
        armStrobe = 1'b1; disarmStrobe = 1'b1;
        tick();
        armStrobe = 1'b0; disarmStrobe = 1'b0;
        checkValue("t7-disarmWins", seqArmed, 0);
        pulseStart();
        checkValue("t7-noStart", seqActive, 0);
        checkValue("t7-acc", startRequestsAccepted, statExp(6));

        // Continuous playback of table 0, stopped by abort.
        armTable(2'd0, 16'd0);
        pulseStart();
        waitValid(1, cnt);
        checkValue("t8-delay0", cnt, 4);
        checkValue("t8-ev", evgSequenceEventTDATA, 8'h20);
        checkValue("t8-rem", seqPassesRemaining, 0);
        tick();
        for (int p = 0; p < 2; p++) begin
            waitValid(0, cnt);
            checkValue("t8-delayN", cnt, 4);
            checkValue("t8-evN", evgSequenceEventTDATA, 8'h20);
            checkValue("t8-activeN", seqActive, 1);
            tick();
        end
        abortStrobe = 1'b1;
        tick();
        abortStrobe = 1'b0;
        expectIdle("t8-abort");

        // Abort while stalled, with a re-arm during playback.
        armTable(2'd1, 16'd1);
        pulseStart();
        armTable(2'd0, 16'd1);
        checkValue("t9-rearmed", seqArmed, 1);
        waitValid(2, cnt);
        checkValue("t9-delay", cnt, 8);
        evgSequenceEventTREADY = 1'b0;
        tick();
        checkValue("t9-stalledValid", evgSequenceEventTVALID, 1);
        abortStrobe = 1'b1;
        tick();
        abortStrobe = 1'b0;
        evgSequenceEventTREADY = 1'b1;
        expectIdle("t9-abort");
        checkValue("t9-armed", seqArmed, 0);
        checkValue("t9-data", evgSequenceEventTDATA, 0);
        tick();
        checkValue("t9-staysIdle", seqActive, 0);
        checkValue("t9-acc", startRequestsAccepted, statExp(8));
        checkValue("t9-stall", stallCycles, statExp(9));

        // Reset mid-playback.
        armTable(2'd1, 16'd3);
        pulseStart();
        waitValid(1, cnt);
        checkValue("t10-delay", cnt, 8);
        #2 evgTxReset = 1'b1;
        #1;
        checkValue("t10-valid", evgSequenceEventTVALID, 0);
        checkValue("t10-data", evgSequenceEventTDATA, 0);
        checkValue("t10-active", seqActive, 0);
        checkValue("t10-busy", seqBusy, 0);
        checkValue("t10-sel", seqActiveSelect, 0);
        checkValue("t10-rem", seqPassesRemaining, 0);
        checkValue("t10-acc", startRequestsAccepted, 0);
        checkValue("t10-ign", startRequestsIgnored, 0);
        checkValue("t10-stall", stallCycles, 0);
        tick();
        evgTxReset = 1'b0;
        checkValue("t10-armed", seqArmed, 0);
        pulseStart();
        checkValue("t10-noStart", seqActive, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/evg_multi_sequencer.md
# evg_multi_sequencer

Parametrised successor to the two-bank event-generator sequencer. It stores SEQUENCE_COUNT independent event tables in one RAM and plays the armed table on each start request. A table plays once, a programmed number of times, or continuously. Event output is an AXI-stream-style request with TREADY back-pressure. It sits in the evgTxClk domain between the trigger logic and the event multiplexer; the CSR/CDC bridge that drives its write and control ports is outside this block.

## Interface
- SEQUENCE_COUNT, 4: number of tables; SEL_W = $clog2(SEQUENCE_COUNT), minimum 1.
- SEQUENCE_RAM_CAPACITY, 2048: entries per table; ADDR_W = $clog2.
- EVENTCODE_WIDTH, 8: event code width.
- SEQUENCE_GAP_WIDTH, 28: gap field width.
- END_OF_TABLE_EVENT_CODE, 8'h7F: terminates a pass.

Ports:
- evgTxClk  in  1  clock, all logic.
- evgTxReset  in  1  asynchronous, active-high reset.
- wrEnable  in  1  write one table entry this cycle.
- wrAddress  in  SEL_W+ADDR_W  {table, entry}.
- wrGap  in  SEQUENCE_GAP_WIDTH  gap field to write.
- wrEvent  in  EVENTCODE_WIDTH  event code to write.
- armStrobe  in  1  arm table armSelect with armRepeat.
- armSelect  in  SEL_W  table to arm.
- armRepeat  in  16  number of passes; 0 = continuous.
- disarmStrobe  in  1  clear the armed state.
- abortStrobe  in  1  stop playback immediately.
- precompletionEvent  in  EVENTCODE_WIDTH  event that drops busy early.
- evgSequenceStart  in  1  start request.
- evgSequenceEventTDATA  out  EVENTCODE_WIDTH  event code.
- evgSequenceEventTVALID  out  1  event request valid.
- evgSequenceEventTREADY  in  1  downstream accept.
- seqArmed, seqActive, seqBusy  out  1 each  status flags.
- seqActiveSelect  out  SEL_W  table currently playing.
- seqPassesRemaining  out  16  passes left, including the current pass.
- startRequestsAccepted, startRequestsIgnored  out  8 each  wrapping counters.
- stallCycles  out  16  saturating stall counter.

## Operation
- Reset: every output and counter is 0, state is IDLE. RAM contents are not reset. A reset mid-playback stops playback at once.
- States: IDLE, PRIME0, PRIME1, RUN.
- Arm: armStrobe registers the select and repeat count and sets seqArmed. Disarm wins over a simultaneous arm. Both are legal while active and affect only the next start.
- Start in IDLE with seqArmed:
  - Enter PRIME0 and increment accepted.
  - Set seqActive=1 and seqBusy=1.
  - Copy the armed select and repeat count; clear seqArmed.
  - A strobe arriving in the same cycle as the start is not seen by that start.
- Start in IDLE without seqArmed: no effect.
- Start while not IDLE: increment ignored; no other effect.
- PRIME0: read entry 0. PRIME1: load gap counter and pending event from entry 0. Then go to RUN.
- RUN:
  - While the gap counter is nonzero, decrement it.
  - When it reaches 0 and the pending event is neither EOT nor an overflow: assert TVALID/TDATA = pending event, load the next entry (prefetched), advance the pointer.
- End of pass: pending event == EOT, or the pointer has passed CAPACITY entries. No event is emitted.
  - Passes remaining > 1, or continuous: decrement passes remaining (not in continuous mode), return to PRIME0.
  - Otherwise: go to IDLE with seqActive=0 and seqBusy=0.
- Precompletion: emitting precompletionEvent on the final pass clears seqBusy. Emitting it on any other pass has no effect.
- Back-pressure: while TVALID && !TREADY, all state freezes, TVALID/TDATA hold, and stallCycles increments (saturating at 16'hFFFF).
- Abort: IDLE next cycle, TVALID=0 (an unaccepted event is dropped), seqActive=0, seqBusy=0, seqArmed=0. Abort takes priority over a start in the same cycle.
- Writes: accepted in every state. Writing the active table gives undefined playback for that pass.

## Timing
- RAM read latency is 1 cycle, registered.
- For start in cycle S, first event TVALID rises in S+3+gap0 (no stall).
- Event k rises gap_k+1 cycles after event k-1 is accepted. A gap of 0 gives back-to-back events with TVALID held high.
- After EOT detected in cycle E, the first event of the next pass is at E+3+gap0.
- A start in the same cycle the block returns to IDLE is ignored.

## Configuration
- EVG_SEQ_STATS_EN defined: startRequestsAccepted, startRequestsIgnored and stallCycles are implemented.
- EVG_SEQ_STATS_EN undefined: those counters are not built and the outputs are tied to 0. All other behaviour is unchanged.

## Structure
- Package evg_seq_pkg: state enum, default EOT code, width helper functions.
- Sub-module evg_seq_ram: simple dual-port RAM, one write port and one registered read port.

## Test plan
- Write table 1 = {gap 5, ev 0x10}, {gap 0, ev 0x11}, {gap 0, EOT}; arm with repeat 1; start in cycle 100 -> 0x10 at cycle 108, 0x11 at cycle 109, idle afterwards, accepted = 1.
- Arm with repeat 3 on the same table -> three passes; seqPassesRemaining reads 3→2→1; each pass's 0x10 arrives 8 cycles after the previous EOT detection.
- Hold TREADY low for 7 cycles on event 0x10 -> TVALID/TDATA held, stallCycles = 7, 0x11 arrives 1 cycle after acceptance.
- Start asserted twice during playback -> ignored = 2; playback unchanged.
- precompletionEvent = 0x10 with repeat 2 -> seqBusy stays high during pass 1 and drops the cycle after 0x10 is emitted in pass 2.
- Abort while TVALID is stalled -> TVALID is 0 next cycle, state IDLE, seqArmed = 0. Reset mid-playback -> all outputs 0.
